argmax_select: RTL

Post-inference classifier stage that sits directly downstream of the fixed-point ReLU inference top. After the engine signals completion, it sequentially sweeps the engine's `out_idx` score mux and reads each signed class score. It tracks the running maximum and reports the winning digit index with a one-cycle valid pulse. The result holds for the system/testbench until the next run.

---
 rtl/argmax_select_if.sv | 25 ++
 rtl/argmax_select.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/argmax_select_if.sv
// Handshake/data bundle between the inference engine score mux and the argmax stage.
interface argmax_select_if #(
  parameter int DATA_WIDTH = 5,
  parameter int IDX_WIDTH  = 4
);
  logic                  start;
  logic                  clear;
  logic [IDX_WIDTH-1:0]  out_idx;
  logic [DATA_WIDTH-1:0] score;
  logic                  busy;
  logic                  valid;
  logic [IDX_WIDTH-1:0]  class_idx;
  logic [DATA_WIDTH-1:0] max_score;
  logic [DATA_WIDTH:0]   margin;

  modport master (
    output start, clear, score,
    input  out_idx, busy, valid, class_idx, max_score, margin
  );

  modport slave (
    input  start, clear, score,
    output out_idx, busy, valid, class_idx, max_score, margin
  );
endinterface

// File: rtl/argmax_select.sv
// Sequential argmax over the engine score mux; reports winning class with a one-cycle valid.
// Optional runner-up margin tracking is built when ARGMAX_MARGIN_EN is defined.
module argmax_select #(
  parameter int DATA_WIDTH  = 5,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  argmax_select_if.slave  bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [IDX_WIDTH-1:0]         LAST_IDX  = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic signed [DATA_WIDTH-1:0] SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                       state, state_nx;
  logic                         init, step, finish;
  logic                         last, beats_best;
  logic [IDX_WIDTH-1:0]         idx, best_idx, best_idx_nx;
  logic signed [DATA_WIDTH-1:0] best, best_nx, score_s;
  logic                         valid_q;
  logic [IDX_WIDTH-1:0]         class_q;
  logic signed [DATA_WIDTH-1:0] max_q;

  assign score_s    = $signed(bus.score);
  assign last       = (idx == LAST_IDX);
  assign beats_best = (score_s > best);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // On the final compare a held start re-arms the sweep directly, giving a
  // result every NUM_CLASSES cycles with no idle cycle in between.
  always_comb begin
    state_nx = state;
    init     = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = SCAN;
          init     = 1'b1;
        end
      end
      SCAN: begin
        step = 1'b1;
        if (last) begin
          finish = 1'b1;
          if (bus.start) init     = 1'b1;
          else           state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (bus.clear) begin
      state_nx = IDLE;
      init     = 1'b0;
      step     = 1'b0;
      finish   = 1'b0;
    end
  end

  always_comb begin
    best_nx     = best;
    best_idx_nx = best_idx;
    if (beats_best) begin
      best_nx     = score_s;
      best_idx_nx = idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      best     <= '0;
      best_idx <= '0;
      valid_q  <= 1'b0;
      class_q  <= '0;
      max_q    <= '0;
    end else if (bus.clear) begin
      idx      <= '0;
      best     <= '0;
      best_idx <= '0;
      valid_q  <= 1'b0;
      class_q  <= '0;
      max_q    <= '0;
    end else begin
      valid_q <= finish;
      if (finish) begin
        class_q <= best_idx_nx;
        max_q   <= best_nx;
      end
      if (init) begin
        idx      <= '0;
        best     <= SCORE_MIN;
        best_idx <= '0;
      end else if (step) begin
        best     <= best_nx;
        best_idx <= best_idx_nx;
        idx      <= finish ? '0 : idx + 1'b1;
      end
    end
  end

`ifdef ARGMAX_MARGIN_EN
  logic signed [DATA_WIDTH-1:0] second, second_nx;
  logic [DATA_WIDTH:0]          margin_q;

  always_comb begin
    second_nx = second;
    if (beats_best)          second_nx = best;
    else if (score_s > second) second_nx = score_s;
  end

  // Sign-extend by one bit so max-minus-runner-up spans the full positive range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      second   <= '0;
      margin_q <= '0;
    end else if (bus.clear) begin
      second   <= '0;
      margin_q <= '0;
    end else begin
      if (finish)
        margin_q <= {best_nx[DATA_WIDTH-1], best_nx} - {second_nx[DATA_WIDTH-1], second_nx};
      if (init)      second <= SCORE_MIN;
      else if (step) second <= second_nx;
    end
  end

  assign bus.margin = margin_q;
`else
  assign bus.margin = '0;
`endif

  assign bus.out_idx   = idx;
  assign bus.busy      = (state == SCAN);
  assign bus.valid     = valid_q;
  assign bus.class_idx = class_q;
  assign bus.max_score = max_q;

endmodule
